// File: rtl/stencil_cache_multi_pkg.sv
// Shared types and constants for the multi-lane stencil (mask-bit) cache.
package gpu_stencil_pkg;

    localparam int STENCIL_LANES_MAX  = 16;
    localparam int STENCIL_ADDR_W_DEF = 17;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_e;

endpackage

// File: rtl/stencil_cache_multi_lane_ram.sv
// One stencil lane: 1-bit wide, 2**ADDR_W deep, single-port RAM with
// synchronous write and registered read-first output.
module stencil_lane_ram
    import gpu_stencil_pkg::*;
#(
    parameter int ADDR_W = STENCIL_ADDR_W_DEF
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_we,
    input  logic              i_wd,
    output logic              o_rd
);

    logic mem_q [2**ADDR_W];
    logic rd_q;

    // No reset: contents and read register are undefined until written.
    always_ff @(posedge clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wd;
        end
        rd_q <= mem_q[i_addr];
    end

    assign o_rd = rd_q;

endmodule

// File: rtl/stencil_cache_multi.sv
// Multi-lane stencil cache with per-lane write enables, 1-cycle reads and a
// bulk-clear sequencer. Define STENCIL_BYPASS_EN for write-first forwarding.
module stencil_cache_multi
    import gpu_stencil_pkg::*;
#(
    parameter int ADDR_W = STENCIL_ADDR_W_DEF,
    parameter int LANES  = 2
) (
    input  logic              clk,
    input  logic              i_nRst,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [LANES-1:0]  i_stencil,
    input  logic [LANES-1:0]  i_wrMask,
    input  logic              i_clearReq,
    input  logic              i_clearVal,
    output logic [LANES-1:0]  o_stencil,
    output logic              o_clearBusy,
    output logic              o_clearDone
);

    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              clr_val_q, clr_val_d;
    logic              done_q, done_d;
    logic              ovr_q;
    logic              vld_q;
    logic              busy;

    logic [ADDR_W-1:0] ram_addr;
    logic [LANES-1:0]  ram_we;
    logic [LANES-1:0]  ram_wd;
    logic [LANES-1:0]  ram_rd;
    logic [LANES-1:0]  rd_data;

    assign busy = (state_q == CLR_RUN);

    always_ff @(posedge clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state_q   <= CLR_IDLE;
            cnt_q     <= '0;
            clr_val_q <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            vld_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clr_val_q <= clr_val_d;
            done_q    <= done_d;
            ovr_q     <= busy;
            vld_q     <= 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_val_d = clr_val_q;
        done_d    = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (i_clearReq) begin
                    state_d   = CLR_RUN;
                    cnt_d     = '0;
                    clr_val_d = i_clearVal;
                end
            end
            CLR_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = CLR_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // The sweep owns the single RAM port while running; user writes are dropped.
    assign ram_addr = busy ? cnt_q : i_addr;
    assign ram_we   = busy ? {LANES{1'b1}} : i_wrMask;
    assign ram_wd   = busy ? {LANES{clr_val_q}} : i_stencil;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        stencil_lane_ram #(
            .ADDR_W (ADDR_W)
        ) u_ram (
            .clk    (clk),
            .i_addr (ram_addr),
            .i_we   (ram_we[k]),
            .i_wd   (ram_wd[k]),
            .o_rd   (ram_rd[k])
        );
    end

`ifdef STENCIL_BYPASS_EN
    // Port is single-address, so any user write hits the word being read.
    logic [LANES-1:0] byp_mask_q;
    logic [LANES-1:0] byp_data_q;

    always_ff @(posedge clk or negedge i_nRst) begin
        if (!i_nRst) begin
            byp_mask_q <= '0;
        end else begin
            byp_mask_q <= busy ? '0 : i_wrMask;
        end
    end

    always_ff @(posedge clk) begin
        byp_data_q <= i_stencil;
    end

    assign rd_data = (ram_rd & ~byp_mask_q) | (byp_data_q & byp_mask_q);
`else
    assign rd_data = ram_rd;
`endif

    // ovr_q covers the first idle cycle, whose read was issued at the last sweep edge.
    always_comb begin
        o_stencil = rd_data;
        if (!vld_q) begin
            o_stencil = '0;
        end else if (busy || ovr_q) begin
            o_stencil = {LANES{clr_val_q}};
        end
    end

    assign o_clearBusy = busy;
    assign o_clearDone = done_q;

endmodule

// File: tb/tb_stencil_cache_multi.sv
// Scoreboard bench for stencil_cache_multi (ADDR_W=4, LANES=4).
module tb_stencil_cache_multi;

    localparam int AW = 4;
    localparam int LN = 4;

    logic          clk = 1'b0;
    logic          i_nRst;
    logic [AW-1:0] i_addr;
    logic [LN-1:0] i_stencil;
    logic [LN-1:0] i_wrMask;
    logic          i_clearReq;
    logic          i_clearVal;
    logic [LN-1:0] o_stencil;
    logic          o_clearBusy;
    logic          o_clearDone;

    always #5 clk = ~clk;

    stencil_cache_multi #(
        .ADDR_W (AW),
        .LANES  (LN)
    ) dut (
        .clk         (clk),
        .i_nRst      (i_nRst),
        .i_addr      (i_addr),
        .i_stencil   (i_stencil),
        .i_wrMask    (i_wrMask),
        .i_clearReq  (i_clearReq),
        .i_clearVal  (i_clearVal),
        .o_stencil   (o_stencil),
        .o_clearBusy (o_clearBusy),
        .o_clearDone (o_clearDone)
    );

    typedef struct {
        logic [LN-1:0] exp;
        int            tag;
    } rd_t;

    rd_t  rd_q[$];
    int   clr_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   busy_cnt = 0;
    logic rd_req   = 1'b0;
    logic mon_pend;

`ifdef STENCIL_BYPASS_EN
    localparam logic [LN-1:0] RDW_ADDR3 = 4'b1001;
    localparam logic [LN-1:0] RDW_ADDR7 = 4'b0110;
`else
    localparam logic [LN-1:0] RDW_ADDR3 = 4'b1010;
    localparam logic [LN-1:0] RDW_ADDR7 = 4'b0000;
`endif

    // Monitor: pops a read expectation one edge after it was issued, and
    // checks sweep length whenever the DUT pulses done.
    initial begin
        forever begin
            @(posedge clk);
            mon_pend = rd_req;
            @(negedge clk);
            if (!i_nRst) begin
                busy_cnt = 0;
            end else begin
                if (mon_pend) begin
                    rd_t r;
                    checks++;
                    if (rd_q.size() == 0) begin
                        errors++;
                        $display("FAIL rd_underflow stencil=%b", o_stencil);
                    end else begin
                        r = rd_q.pop_front();
                        if (o_stencil !== r.exp) begin
                            errors++;
                            $display("FAIL read tag=%0d got=%b exp=%b", r.tag, o_stencil, r.exp);
                        end
                    end
                end
                if (o_clearBusy) busy_cnt++;
                if (o_clearDone) begin
                    checks++;
                    if (clr_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done busy_cycles=%0d exp=none", busy_cnt);
                    end else begin
                        int e;
                        e = clr_q.pop_front();
                        if (busy_cnt != e || o_clearBusy !== 1'b0) begin
                            errors++;
                            $display("FAIL clear_len got=%0d busy_at_done=%b exp=%0d busy_at_done=0",
                                     busy_cnt, o_clearBusy, e);
                        end
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [LN-1:0] act, input logic [LN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [AW-1:0] a, input logic [LN-1:0] d, input logic [LN-1:0] m,
                       input logic req, input logic val, input logic rd,
                       input logic [LN-1:0] e, input int tag);
        i_addr     = a;
        i_stencil  = d;
        i_wrMask   = m;
        i_clearReq = req;
        i_clearVal = val;
        rd_req     = rd;
        if (rd) rd_q.push_back('{e, tag});
        @(posedge clk);
        #1;
    endtask

    initial begin
        int j;
        i_nRst     = 1'b0;
        i_addr     = '0;
        i_stencil  = '0;
        i_wrMask   = '0;
        i_clearReq = 1'b0;
        i_clearVal = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stencil", o_stencil, 4'b0000);
        chk("rst_busy", {3'b000, o_clearBusy}, 4'b0000);
        chk("rst_done", {3'b000, o_clearDone}, 4'b0000);
        i_nRst = 1'b1;

        // Masked writes and read-during-write at address 3.
        cyc(4'd3, 4'b1010, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 0);
        cyc(4'd3, 4'b0101, 4'b0011, 1'b0, 1'b0, 1'b1, RDW_ADDR3, 1);
        cyc(4'd3, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1001, 2);

        // Clear to 1, with an ignored write and an ignored second request.
        clr_q.push_back(16);
        cyc(4'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 0);
        for (int i = 0; i < 16; i++) begin
            j = i;
            if (i == 2)
                cyc(4'd5, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1, 4'b1111, 10);
            else if (i == 5)
                cyc(j[AW-1:0], 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1111, 11);
            else
                cyc(j[AW-1:0], 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111, 12);
        end
        for (int i = 0; i < 16; i++) begin
            j = i;
            cyc(j[AW-1:0], 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b1111, 100 + i);
        end

        // Read-during-write at address 7.
        cyc(4'd7, 4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, 4'b0000, 0);
        cyc(4'd7, 4'b1111, 4'b0110, 1'b0, 1'b0, 1'b1, RDW_ADDR7, 20);
        cyc(4'd7, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0110, 21);

        // Reset in the middle of a sweep: no done pulse may follow.
        cyc(4'd0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0000, 0);
        repeat (6) cyc(4'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0);
        chk("mid_busy_pre", {3'b000, o_clearBusy}, 4'b0001);
        i_nRst = 1'b0;
        #1;
        chk("mid_rst_busy", {3'b000, o_clearBusy}, 4'b0000);
        chk("mid_rst_stencil", o_stencil, 4'b0000);
        chk("mid_rst_done", {3'b000, o_clearDone}, 4'b0000);
        @(posedge clk);
        #1;
        i_nRst = 1'b1;

        // Clear request with a same-cycle write; the sweep overwrites it.
        clr_q.push_back(16);
        cyc(4'd2, 4'b1111, 4'b1111, 1'b1, 1'b0, 1'b0, 4'b0000, 0);
        repeat (16) cyc(4'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0);
        for (int i = 0; i < 16; i++) begin
            j = (i + 2) % 16;
            cyc(j[AW-1:0], 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000, 200 + j);
        end

        repeat (3) cyc(4'd0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 0);
        checks++;
        if (clr_q.size() != 0) begin
            errors++;
            $display("FAIL missing_done pending=%0d exp=0", clr_q.size());
        end
        checks++;
        if (rd_q.size() != 0) begin
            errors++;
            $display("FAIL reads_pending pending=%0d exp=0", rd_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
